// File: rtl/uart_rx_core.sv
// 8N1 UART receiver. It has a 2-flop input synchronizer, mid-bit sampling and a
// single-entry holding register (rx_data/rx_valid) that is released by rx_ack.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       uart_rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          overrun_q, overrun_d;
  logic          rxd_s;

  assign rxd_s = sync_q[1];

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    sync_d    = {sync_q[0], uart_rxd};
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~rx_ack;
    ferr_d    = 1'b0;
    overrun_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d   = rxd_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == FULL_LAST) begin
          timer_d   = '0;
          shift_d   = {rxd_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_d == 3'd0) state_d = STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == FULL_LAST) begin
          timer_d = '0;
          state_d = IDLE;
          if (!rxd_s) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rx_ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only here and only with non-blocking assignments, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign rx_ferr    = ferr_q;
  assign rx_overrun = overrun_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core at CLKS_PER_BIT=8. The stimulus is a table of frames plus
// sequences for latency, glitch, reset and sweep. A negedge monitor compares deliveries with a queue.
module tb_uart_rx_core;

  localparam int CPB    = 8;
  localparam int HALF   = CPB / 2;
  localparam int LAT    = 2 + HALF + 9 * CPB + 1;
  localparam int C_ACK  = LAT - 1;

  typedef enum {K_DELIVER, K_FERR, K_OVERRUN} kind_e;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack_stop;
    kind_e      kind;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_overrun, rx_busy;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int ferr_cnt = 0, ovr_cnt = 0, deliv_cnt = 0, busy_cnt = 0;
  int rise_cycle = -1, fall_cycle = 0;
  logic ack_hold = 1'b0;
  logic [7:0] exp_q[$];

  logic       valid_prev = 1'b0, ack_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .uart_rxd   (uart_rxd),
    .rx_ack     (rx_ack),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ferr    (rx_ferr),
    .rx_overrun (rx_overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A delivery is a cycle where rx_valid is high and the previous cycle had it low or acked.
  always @(negedge clk) begin
    if (!reset_b) begin
      valid_prev = 1'b0;
      ack_prev   = 1'b0;
      data_prev  = rx_data;
    end else begin
      if (rx_ferr) ferr_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_busy) busy_cnt++;
      check("ferr_ovr_exclusive", {31'd0, rx_ferr & rx_overrun}, 32'd0);
      if (rx_valid && (!valid_prev || ack_prev)) begin
        deliv_cnt++;
        if (!valid_prev) rise_cycle = cycle_cnt;
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("deliver_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end else begin
        check("data_stable", {24'd0, rx_data}, {24'd0, data_prev});
      end
      valid_prev = rx_valid;
      ack_prev   = rx_ack;
      data_prev  = rx_data;
    end
  end

  // Call this right after tick(). The pin falls during cycle fall_cycle, and rst_at < 0 means no reset pulse.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input logic ack_stop,
                             input int rst_at, input bit push);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (push) exp_q.push_back(d);
    fall_cycle = cycle_cnt;
    for (int c = 0; c < 10 * CPB; c++) begin
      uart_rxd = bits[c / CPB];
      rx_ack   = ack_hold || (ack_stop && c == C_ACK);
      if (rst_at >= 0 && c == rst_at) reset_b = 1'b0;
      if (rst_at >= 0 && c == rst_at + 2) reset_b = 1'b1;
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_data", {24'd0, rx_data}, 32'd0);
        check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_mid_pulses", {30'd0, rx_ferr, rx_overrun}, 32'd0);
      end
      tick();
    end
    uart_rxd = 1'b1;
    rx_ack   = ack_hold;
  endtask

  vec_t tbl[10];

  initial begin
    int f0, o0, d0, b0;
    tbl[0] = '{8'h11, 1'b1, 1'b0, K_DELIVER, 1'b1, 8'h11};
    tbl[1] = '{8'h22, 1'b1, 1'b0, K_OVERRUN, 1'b1, 8'h11};
    tbl[2] = '{8'h22, 1'b1, 1'b1, K_DELIVER, 1'b1, 8'h22};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, K_FERR,    1'b1, 8'h22};
    tbl[4] = '{8'hC3, 1'b1, 1'b1, K_DELIVER, 1'b1, 8'hC3};
    tbl[5] = '{8'h81, 1'b0, 1'b1, K_FERR,    1'b0, 8'hC3};
    tbl[6] = '{8'h3C, 1'b0, 1'b0, K_FERR,    1'b0, 8'hC3};
    tbl[7] = '{8'h7E, 1'b1, 1'b0, K_DELIVER, 1'b1, 8'h7E};
    tbl[8] = '{8'h00, 1'b1, 1'b1, K_DELIVER, 1'b1, 8'h00};
    tbl[9] = '{8'hFF, 1'b1, 1'b0, K_OVERRUN, 1'b1, 8'h00};

    repeat (3) tick();
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_ferr", {31'd0, rx_ferr}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    check("rst_busy", {31'd0, rx_busy}, 32'd0);
    reset_b = 1'b1;
    repeat (4) tick();
    check("idle_busy", {31'd0, rx_busy}, 32'd0);

    foreach (tbl[i]) begin
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      drive_frame(tbl[i].data, tbl[i].stop, tbl[i].ack_stop, -1, tbl[i].kind == K_DELIVER);
      repeat (2 * CPB) tick();
      check($sformatf("tbl%0d_valid", i), {31'd0, rx_valid}, {31'd0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_data", i), {24'd0, rx_data}, {24'd0, tbl[i].exp_data});
      check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, (tbl[i].kind == K_FERR) ? 1 : 0);
      check($sformatf("tbl%0d_ovr", i), ovr_cnt - o0, (tbl[i].kind == K_OVERRUN) ? 1 : 0);
    end

    // Clear the holding register, then measure the latency of 8'hA5.
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    check("ack_clear", {31'd0, rx_valid}, 32'd0);
    tick();
    rise_cycle = -1;
    drive_frame(8'hA5, 1'b1, 1'b0, -1, 1'b1);
    repeat (10) tick();
    check("a5_latency", rise_cycle - fall_cycle, LAT);
    check("a5_hold_valid", {31'd0, rx_valid}, 32'd1);
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    rx_ack = 1'b1;
    check("a5_before_ack", {31'd0, rx_valid}, 32'd1);
    tick();
    rx_ack = 1'b0;
    check("a5_after_ack", {31'd0, rx_valid}, 32'd0);
    tick();

    // Low glitch of 3 cycles.
    f0 = ferr_cnt; o0 = ovr_cnt; d0 = deliv_cnt; b0 = busy_cnt;
    uart_rxd = 1'b0;
    repeat (3) tick();
    uart_rxd = 1'b1;
    repeat (20) tick();
    check("glitch_busy_cycles", busy_cnt - b0, 4);
    check("glitch_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    check("glitch_no_deliver", deliv_cnt - d0, 0);
    check("glitch_valid", {31'd0, rx_valid}, 32'd0);

    // Reset during data bit 4 of 8'hFF, then a clean 8'h5A.
    drive_frame(8'h96, 1'b1, 1'b0, -1, 1'b1);
    repeat (2 * CPB) tick();
    check("pre_rst_data", {24'd0, rx_data}, 32'h0000_0096);
    f0 = ferr_cnt; o0 = ovr_cnt;
    drive_frame(8'hFF, 1'b1, 1'b0, 5 * CPB + 2, 1'b0);
    repeat (2 * CPB) tick();
    check("post_rst_valid", {31'd0, rx_valid}, 32'd0);
    check("post_rst_data", {24'd0, rx_data}, 32'd0);
    check("post_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("post_rst_pulses", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    drive_frame(8'h5A, 1'b1, 1'b0, -1, 1'b1);
    repeat (2 * CPB) tick();
    check("after_rst_5a_valid", {31'd0, rx_valid}, 32'd1);
    check("after_rst_5a_data", {24'd0, rx_data}, 32'h0000_005A);

    // Back-to-back sweep of all byte values with rx_ack held high.
    ack_hold = 1'b1;
    rx_ack = 1'b1;
    tick();
    f0 = ferr_cnt; o0 = ovr_cnt; d0 = deliv_cnt;
    for (int b = 0; b < 256; b++) drive_frame(8'(b), 1'b1, 1'b0, -1, 1'b1);
    repeat (2 * CPB) tick();
    ack_hold = 1'b0;
    rx_ack = 1'b0;
    tick();
    check("sweep_delivered", deliv_cnt - d0, 256);
    check("sweep_ferr", ferr_cnt - f0, 0);
    check("sweep_overrun", ovr_cnt - o0, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range >= 4.
REQ-002 SHALL have ports, in this order:
- clk  input  1  system clock, rising edge.
- reset_b  input  1  reset.
- uart_rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
- rx_ack  input  1  consumer has taken rx_data; sampled on rising clk.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ferr  output  1  one-cycle pulse on framing error.
- rx_overrun  output  1  one-cycle pulse on byte lost to a full holding register.
- rx_busy  output  1  high while a frame is in progress (any state except IDLE).
REQ-003 SHALL use one clock, clk, for all sequential logic; reset_b is asynchronous and active-low.

Function
REQ-004 SHALL pass uart_rxd through a 2-flop synchronizer; all logic below uses the synchronized value rxd_s, which lags the pin by 2 clk cycles.
REQ-005 SHALL implement states IDLE, START, DATA, STOP.
REQ-006 IDLE: on the first cycle with rxd_s=0 (cycle t0), SHALL enter START and clear the bit-timer.
REQ-007 START: at t0 + CLKS_PER_BIT/2 (integer division), SHALL sample rxd_s.
- If 0: enter DATA.
- If 1: treat as a glitch and return to IDLE with no output pulse.
REQ-008 DATA: SHALL sample data bit i (i=0..7) at t0 + CLKS_PER_BIT/2 + (i+1)*CLKS_PER_BIT into a shift register, LSB first; after bit 7, enter STOP.
REQ-009 STOP: SHALL sample at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT, then return to IDLE in the next cycle; there is no wait for the end of the stop bit.
REQ-010 Stop sample = 1 (valid frame):
- If rx_valid=0, or rx_ack=1 in the same cycle: SHALL load rx_data and drive rx_valid=1 from the next cycle.
- If rx_valid=1 and rx_ack=0: SHALL drop the new byte, keep the old rx_data, and pulse rx_overrun for 1 cycle.
REQ-011 Stop sample = 0: SHALL discard the byte, leave rx_data/rx_valid unchanged, pulse rx_ferr for 1 cycle, and return to IDLE; a line still held low then restarts detection per REQ-006.
REQ-012 rx_ack with rx_valid=1 and no simultaneous load SHALL clear rx_valid in the next cycle; rx_ack with rx_valid=0 SHALL have no effect.
REQ-013 The bit-timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap within a frame; the bit counter is 3 bits, and its wrap from 7 to 0 marks the DATA-to-STOP transition.
REQ-014 rx_data SHALL change only on a load per REQ-010; rx_ferr and rx_overrun SHALL never be asserted in the same cycle.
REQ-015 Latency SHALL be: rx_valid rises at (pin falling edge) + 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.

Reset
REQ-016 While reset_b=0, SHALL hold:
- synchronizer flops = 1;
- state = IDLE;
- rx_data = 8'h00;
- rx_valid, rx_ferr, rx_overrun, rx_busy = 0;
- timers = 0.
REQ-017 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, a line held low SHALL be treated as a new start per REQ-006.

Verification (CLKS_PER_BIT=8)
REQ-018 Byte 8'hA5, stop bit 1 -> rx_valid rises exactly 2+4+72+1=79 cycles after the pin falling edge with rx_data=8'hA5; rx_valid holds until rx_ack, then clears 1 cycle later.
REQ-019 Low pulse of 3 cycles on an idle line -> START check sees 1, state returns to IDLE, rx_busy high for 4 cycles, no rx_valid/rx_ferr/rx_overrun.
REQ-020 Byte 8'h3C with stop bit 0 -> rx_ferr pulses 1 cycle; rx_valid stays 0; rx_data unchanged.
REQ-021 Bytes 8'h11 then 8'h22 back-to-back, no rx_ack -> rx_data=8'h11, rx_valid=1, rx_overrun pulses once at the second stop sample; then the second sequence is repeated with rx_ack=1 in the stop-sample cycle -> rx_data=8'h22, rx_valid stays 1, no overrun.
REQ-022 reset_b pulsed low during data bit 4 of 8'hFF -> all outputs return to reset values; the next clean frame 8'h5A is received correctly.
REQ-023 Sweep all 256 byte values back-to-back with 1-bit stop, rx_ack asserted every cycle -> every byte is delivered in order, with zero ferr and zero overrun pulses.
